// File: rtl/glyph_pkg.sv
// Shared constants and RGB field helpers for the glyph render pipeline.
package glyph_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 8;
    localparam logic [3:0] CHAR_BLANK = 4'd15;

    typedef enum int {CH_R = 0, CH_G = 1, CH_B = 2} rgb_ch_e;

    // Packed colour is {R,G,B}: red occupies the most significant field.
    function automatic int rgb_lsb(input int ch, input int color_w);
        return (2 - ch) * color_w;
    endfunction

    function automatic int rgb_msb(input int ch, input int color_w);
        return rgb_lsb(ch, color_w) + color_w - 1;
    endfunction

endpackage

// File: rtl/font_rom_glyph.sv
// Combinational 8x8 digit font; codes 10..15 render as blank cells.
module font_rom_glyph
    import glyph_pkg::*;
(
    input  logic [3:0]         char_i,
    input  logic [2:0]         row_i,
    output logic [GLYPH_W-1:0] bits_o
);

    logic [GLYPH_W*GLYPH_H-1:0] glyph;

    // Row 0 sits in the most significant byte, bit 7 of each byte is leftmost.
    always_comb begin
        glyph = '0;
        case (char_i)
            4'd0: glyph = 64'h3C666E7666663C00;
            4'd1: glyph = 64'h1838181818187E00;
            4'd2: glyph = 64'h3C66060C30607E00;
            4'd3: glyph = 64'h3C66061C06663C00;
            4'd4: glyph = 64'h0C1C3C6C7E0C0C00;
            4'd5: glyph = 64'h7E607C0606663C00;
            4'd6: glyph = 64'h3C607C6666663C00;
            4'd7: glyph = 64'h7E060C1830303000;
            4'd8: glyph = 64'h3C66663C66663C00;
            4'd9: glyph = 64'h3C66663E060C3800;
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14, CHAR_BLANK: glyph = '0;
        endcase
        bits_o = glyph[{~row_i, 3'b000} +: GLYPH_W];
    end

endmodule

// File: rtl/glyph_render_pipe.sv
// Two-stage glyph pixel renderer: S1 captures font row, column and (blink-swapped)
// colours; S2 holds the selected colour with ready/valid backpressure.
module glyph_render_pipe
    import glyph_pkg::*;
#(
    parameter int SCALE_LOG2  = 2,
    parameter int COLOR_W     = 4,
    parameter int BLINK_DIV_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            char,
    input  logic [3+SCALE_LOG2:0] px_x,
    input  logic [2+SCALE_LOG2:0] px_y,
    input  logic [3*COLOR_W-1:0]  fg,
    input  logic [3*COLOR_W-1:0]  bg,
    input  logic                  cursor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3*COLOR_W-1:0]  rgb
);

    localparam int RGB_W  = 3 * COLOR_W;
    localparam int STAGES = 2;

    logic [BLINK_DIV_W-1:0] blink_q;
    logic [STAGES:1]        vld_q, vld_d;
    logic [GLYPH_W-1:0]     rom_bits, s1_bits_q;
    logic [3:0]             s1_col_q;
    logic [RGB_W-1:0]       s1_fg_q, s1_bg_q, rgb_q, rgb_d, pix_rgb;
    logic                   accept, s2_adv, swap, lit;

    font_rom_glyph u_font (
        .char_i (char),
        .row_i  (px_y[2+SCALE_LOG2:SCALE_LOG2]),
        .bits_o (rom_bits)
    );

    assign s2_adv    = !vld_q[2] || out_ready;
    assign in_ready  = !vld_q[1] || !vld_q[2] || out_ready;
    assign accept    = in_valid && in_ready;
    assign swap      = cursor && blink_q[BLINK_DIV_W-1];
    assign out_valid = vld_q[2];
    assign rgb       = rgb_q;

    // Columns 8..15 of the unscaled index fall outside the glyph and stay background.
    assign lit = !s1_col_q[3] && s1_bits_q[3'd7 - s1_col_q[2:0]];

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        localparam int LSB = rgb_lsb(ch, COLOR_W);
        assign pix_rgb[LSB +: COLOR_W] = lit ? s1_fg_q[LSB +: COLOR_W] : s1_bg_q[LSB +: COLOR_W];
    end

    always_comb begin
        vld_d    = vld_q;
        vld_d[1] = accept || (vld_q[1] && !s2_adv);
        if (s2_adv) vld_d[2] = vld_q[1];
        rgb_d = (s2_adv && vld_q[1]) ? pix_rgb : rgb_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q <= '0;
            vld_q   <= '0;
            rgb_q   <= '0;
        end else begin
            blink_q <= blink_q + {{(BLINK_DIV_W-1){1'b0}}, 1'b1};
            vld_q   <= vld_d;
            rgb_q   <= rgb_d;
        end
    end

    // S1 payload; blink swap is resolved here so the phase is the one at capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_bits_q <= '0;
            s1_col_q  <= '0;
            s1_fg_q   <= '0;
            s1_bg_q   <= '0;
        end else if (accept) begin
            s1_bits_q <= rom_bits;
            s1_col_q  <= px_x[3+SCALE_LOG2:SCALE_LOG2];
            s1_fg_q   <= swap ? bg : fg;
            s1_bg_q   <= swap ? fg : bg;
        end
    end

endmodule
